// File: rtl/pi1_dcv_pkg.sv
// Shared pi1 definitions: op encodings, FSM states and a constant clog2.
package pi1_dcv_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  // ST_FIN is the single settle cycle of an access that issues no beats.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BEAT = 2'b01,
    ST_RESP = 2'b10,
    ST_FIN  = 2'b11
  } dcv_state_e;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // RD and RW both return data to the master.
  function automatic logic op_reads(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/pi1_dcv_selscan.sv
// Next-active-beat finder for the pi1 down-converter.
// Returns the first beat index >= start_i that should be issued, or flags
// that none is left. With PI1_DCV_SKIPZEROSEL_EN defined, beats whose sel
// slice is all-zero are skipped; otherwise every beat is active and the
// block is a plain incrementer.
module pi1_dcv_selscan
  import pi1_dcv_pkg::*;
#(
  parameter int NBEAT = 4,
  parameter int SELW  = 4,
  parameter int BW    = 2
) (
  input  logic [SELW-1:0] sel_i,
  input  logic [BW:0]     start_i,
  output logic [BW-1:0]   next_o,
  output logic            none_o
);

`ifdef PI1_DCV_SKIPZEROSEL_EN
  localparam int SLW = SELW / NBEAT;

  logic [NBEAT-1:0] active;

  // A beat is active when any byte select in its slice is set.
  always_comb begin
    active = '0;
    for (int i = 0; i < NBEAT; i++) begin
      active[i] = |sel_i[i*SLW +: SLW];
    end
  end

  // Scan downwards so the lowest qualifying index is the one left standing.
  always_comb begin
    next_o = '0;
    none_o = 1'b1;
    for (int i = NBEAT - 1; i >= 0; i--) begin
      if (active[i] && ((BW+1)'(i) >= start_i)) begin
        next_o = BW'(i);
        none_o = 1'b0;
      end else begin
        next_o = next_o;
        none_o = none_o;
      end
    end
  end
`else
  logic [SELW-1:0] sel_unused;
  assign sel_unused = sel_i;
  assign next_o     = start_i[BW-1:0];
  assign none_o     = start_i[BW];
`endif

endmodule

// File: rtl/pi1_dcv.sv
// pi1 data-width down-converter: splits one wide master access into
// MARCHBITSZ/SARCHBITSZ serialised narrow slave beats and reassembles read
// data. Optional build macro PI1_DCV_SKIPZEROSEL_EN suppresses beats whose
// byte-select slice is zero.
module pi1_dcv
  import pi1_dcv_pkg::*;
#(
  parameter  int MARCHBITSZ = 32,
  parameter  int SARCHBITSZ = 8,
  localparam int R          = MARCHBITSZ / SARCHBITSZ,
  localparam int BW         = clog2(R),
  localparam int MADDRBITSZ = MARCHBITSZ - clog2(MARCHBITSZ / 8),
  localparam int SADDRBITSZ = MADDRBITSZ + BW,
  localparam int MSELW      = MARCHBITSZ / 8,
  localparam int SSELW      = SARCHBITSZ / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            m_op_i,
  input  logic [MADDRBITSZ-1:0] m_addr_i,
  input  logic [MARCHBITSZ-1:0] m_data_i,
  output logic [MARCHBITSZ-1:0] m_data_o,
  input  logic [MSELW-1:0]      m_sel_i,
  output logic                  m_rdy_o,
  output logic [1:0]            s_op_o,
  output logic [SADDRBITSZ-1:0] s_addr_o,
  output logic [SARCHBITSZ-1:0] s_data_o,
  input  logic [SARCHBITSZ-1:0] s_data_i,
  output logic [SSELW-1:0]      s_sel_o,
  input  logic                  s_rdy_i
);

  dcv_state_e state_q, state_d;

  logic [1:0]            op_q, op_d;
  logic [MADDRBITSZ-1:0] addr_q, addr_d;
  logic [MARCHBITSZ-1:0] wdata_q, wdata_d;
  logic [MSELW-1:0]      sel_q, sel_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [MARCHBITSZ-1:0] rdata_q, rdata_d;
  logic [MARCHBITSZ-1:0] m_data_q, m_data_d;
  logic                  m_rdy_q, m_rdy_d;
  logic [1:0]            s_op_q, s_op_d;
  logic [SADDRBITSZ-1:0] s_addr_q, s_addr_d;
  logic [SARCHBITSZ-1:0] s_data_q, s_data_d;
  logic [SSELW-1:0]      s_sel_q, s_sel_d;

  logic [MSELW-1:0]      scan_sel;
  logic [BW:0]           scan_start;
  logic [BW-1:0]         scan_next;
  logic                  scan_none;
  logic [MARCHBITSZ-1:0] src_data;
  logic [SARCHBITSZ-1:0] load_data;
  logic [SSELW-1:0]      load_sel;
  logic [MARCHBITSZ-1:0] rdata_capt;

  // Scan from beat 0 of the incoming request in IDLE, else past the current beat.
  always_comb begin
    if (state_q == ST_IDLE) begin
      scan_sel   = m_sel_i;
      scan_start = '0;
      src_data   = m_data_i;
    end else begin
      scan_sel   = sel_q;
      scan_start = {1'b0, beat_q} + (BW+1)'(1);
      src_data   = wdata_q;
    end
  end

  pi1_dcv_selscan #(
    .NBEAT (R),
    .SELW  (MSELW),
    .BW    (BW)
  ) u_selscan (
    .sel_i   (scan_sel),
    .start_i (scan_start),
    .next_o  (scan_next),
    .none_o  (scan_none)
  );

  // Extract the write lane and sel slice of the beat about to be issued.
  always_comb begin
    load_data = '0;
    load_sel  = '0;
    for (int k = 0; k < R; k++) begin
      if (scan_next == BW'(k)) begin
        load_data = src_data[k*SARCHBITSZ +: SARCHBITSZ];
        load_sel  = scan_sel[k*SSELW +: SSELW];
      end else begin
        load_data = load_data;
        load_sel  = load_sel;
      end
    end
  end

  // Merge the slave read data into the current lane for RD/RW accesses.
  always_comb begin
    rdata_capt = rdata_q;
    for (int k = 0; k < R; k++) begin
      if ((beat_q == BW'(k)) && op_reads(op_q)) begin
        rdata_capt[k*SARCHBITSZ +: SARCHBITSZ] = s_data_i;
      end else begin
        rdata_capt = rdata_capt;
      end
    end
  end

  // Next-state and registered-output logic of the beat sequencer.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    m_data_d = m_data_q;
    m_rdy_d  = m_rdy_q;
    s_op_d   = s_op_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    s_sel_d  = s_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (m_op_i != PINOOP) begin
          op_d    = m_op_i;
          addr_d  = m_addr_i;
          wdata_d = m_data_i;
          sel_d   = m_sel_i;
          rdata_d = '0;
          m_rdy_d = 1'b0;
          if (scan_none) begin
            state_d = ST_FIN;
          end else begin
            state_d  = ST_BEAT;
            beat_d   = scan_next;
            s_op_d   = m_op_i;
            s_addr_d = {m_addr_i, scan_next};
            s_data_d = load_data;
            s_sel_d  = load_sel;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEAT: begin
        if (s_rdy_i) begin
          s_op_d  = PINOOP;
          state_d = ST_RESP;
        end else begin
          state_d = ST_BEAT;
        end
      end
      ST_RESP: begin
        if (s_rdy_i) begin
          rdata_d = rdata_capt;
          if (scan_none) begin
            state_d  = ST_IDLE;
            m_rdy_d  = 1'b1;
            m_data_d = rdata_capt;
          end else begin
            state_d  = ST_BEAT;
            beat_d   = scan_next;
            s_op_d   = op_q;
            s_addr_d = {addr_q, scan_next};
            s_data_d = load_data;
            s_sel_d  = load_sel;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_FIN: begin
        state_d  = ST_IDLE;
        m_rdy_d  = 1'b1;
        m_data_d = rdata_q;
      end
      default: begin
        state_d = ST_IDLE;
        m_rdy_d = 1'b1;
        s_op_d  = PINOOP;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= PINOOP;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      m_data_q <= '0;
      m_rdy_q  <= 1'b1;
      s_op_q   <= PINOOP;
      s_addr_q <= '0;
      s_data_q <= '0;
      s_sel_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      m_data_q <= m_data_d;
      m_rdy_q  <= m_rdy_d;
      s_op_q   <= s_op_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      s_sel_q  <= s_sel_d;
    end
  end

  assign m_data_o = m_data_q;
  assign m_rdy_o  = m_rdy_q;
  assign s_op_o   = s_op_q;
  assign s_addr_o = s_addr_q;
  assign s_data_o = s_data_q;
  assign s_sel_o  = s_sel_q;

endmodule

// File: tb/tb_pi1_dcv.sv
// Self-checking bench for pi1_dcv (32-bit master, 8-bit slave) with a
// transaction-level reference model and a randomly stalling slave.
module tb_pi1_dcv;

`ifdef PI1_DCV_SKIPZEROSEL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  m_op_i;
  logic [29:0] m_addr_i;
  logic [31:0] m_data_i;
  logic [31:0] m_data_o;
  logic [3:0]  m_sel_i;
  logic        m_rdy_o;
  logic [1:0]  s_op_o;
  logic [31:0] s_addr_o;
  logic [7:0]  s_data_o;
  logic [7:0]  s_data_i;
  logic [0:0]  s_sel_o;
  logic        s_rdy_i;

  int n_vec = 0;
  int n_err = 0;

  pi1_dcv #(.MARCHBITSZ(32), .SARCHBITSZ(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_op_i(m_op_i), .m_addr_i(m_addr_i), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_sel_i(m_sel_i), .m_rdy_o(m_rdy_o),
    .s_op_o(s_op_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_sel_o(s_sel_o), .s_rdy_i(s_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One master access. fixed_data: slave returns 0x11,0x22,...; rnd: random
  // s_rdy_i; otherwise zero-wait except stall_len low cycles while beat
  // number stall_beat is presented.
  task automatic do_txn(input logic [1:0] op, input logic [29:0] addr,
                        input logic [31:0] data, input logic [3:0] sel,
                        input bit rnd, input bit fixed_data,
                        input int stall_beat, input int stall_len);
    int          exp_k[$];
    logic [31:0] ob_addr[$];
    logic [7:0]  ob_data[$];
    logic        ob_sel[$];
    logic [1:0]  ob_op[$];
    logic [7:0]  rets[$];
    logic [31:0] snap_addr;
    logic [7:0]  snap_data;
    logic        snap_sel;
    logic [1:0]  snap_op;
    logic [31:0] md;
    logic [1:0]  kk;
    int          phase, lowcyc, stalls, stall_left, nb, nmin;
    bit          held, done, rdy;
    logic [7:0]  sdat;

    for (int k = 0; k < 4; k++) begin
      if (!SKIP || sel[k]) exp_k.push_back(k);
    end
    m_op_i = op; m_addr_i = addr; m_data_i = data; m_sel_i = sel;
    @(posedge clk_i); #1;
    phase = 0; lowcyc = 0; stalls = 0; stall_left = stall_len;
    held = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (m_rdy_o) begin
        done = 1'b1;
      end else begin
        // junk master request while busy must be ignored
        m_op_i = 2'($urandom_range(1, 3));
        m_addr_i = 30'($urandom); m_data_i = $urandom; m_sel_i = 4'($urandom);
        lowcyc++;
        if (rnd) rdy = ($urandom_range(0, 3) != 0);
        else if (phase == 0 && s_op_o != 2'b00 && ob_addr.size() == stall_beat && stall_left > 0) begin
          rdy = 1'b0; stall_left--;
        end else rdy = 1'b1;
        sdat = fixed_data ? 8'(8'h11 * (rets.size() + 1)) : 8'($urandom);
        if (phase == 0) begin
          if (s_op_o != 2'b00) begin
            if (held) begin
              check_eq("stable_op", s_op_o, snap_op);
              check_eq("stable_addr", s_addr_o, snap_addr);
              check_eq("stable_data", s_data_o, snap_data);
              check_eq("stable_sel", s_sel_o, snap_sel);
            end else begin
              snap_op = s_op_o; snap_addr = s_addr_o; snap_data = s_data_o; snap_sel = s_sel_o[0];
              held = 1'b1;
            end
            if (!rdy) stalls++;
            if (rdy) begin
              ob_addr.push_back(s_addr_o); ob_data.push_back(s_data_o);
              ob_sel.push_back(s_sel_o[0]); ob_op.push_back(s_op_o);
              phase = 1; held = 1'b0;
            end
          end
        end else begin
          check_eq("resp_noop", s_op_o, 2'b00);
          if (!rdy) stalls++;
          if (rdy) begin rets.push_back(sdat); phase = 0; end
        end
        s_rdy_i = rdy; s_data_i = sdat;
        @(posedge clk_i); #1;
      end
    end
    m_op_i = 2'b00; s_rdy_i = 1'b0;
    if (!done) check_eq("timeout", 64'd0, 64'd1);
    nb = exp_k.size();
    check_eq("nbeats", ob_addr.size(), nb);
    nmin = (ob_addr.size() < nb) ? ob_addr.size() : nb;
    for (int i = 0; i < nmin; i++) begin
      kk = 2'(exp_k[i]);
      check_eq("beat_addr", ob_addr[i], {addr, kk});
      check_eq("beat_data", ob_data[i], data[exp_k[i]*8 +: 8]);
      check_eq("beat_sel", ob_sel[i], sel[exp_k[i]]);
      check_eq("beat_op", ob_op[i], op);
    end
    md = 32'd0;
    for (int i = 0; i < nb && i < rets.size(); i++) begin
      if (op[1]) md[exp_k[i]*8 +: 8] = rets[i];
    end
    check_eq("mdata", m_data_o, md);
    check_eq("latency", lowcyc, (nb == 0) ? 1 : 2 * nb + stalls);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [3:0]  rsel;
    rst_i = 1'b1; m_op_i = 2'b00; m_addr_i = 30'd0; m_data_i = 32'd0; m_sel_i = 4'd0;
    s_data_i = 8'd0; s_rdy_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_m_rdy", m_rdy_o, 1'b1);
    check_eq("rst_m_data", m_data_o, 32'd0);
    check_eq("rst_s_op", s_op_o, 2'b00);
    check_eq("rst_s_addr", s_addr_o, 32'd0);
    check_eq("rst_s_data", s_data_o, 8'd0);
    check_eq("rst_s_sel", s_sel_o, 1'b0);
    rst_i = 1'b0;

    // RD with fixed slave data 0x11..0x44
    do_txn(2'b10, 30'h100, 32'h0, 4'b1111, 1'b0, 1'b1, -1, 0);
    check_eq("rd_word", m_data_o, 32'h44332211);

    // reset during RESP of beat 2
    s_rdy_i = 1'b1; s_data_i = 8'h5A;
    m_op_i = 2'b10; m_addr_i = 30'h3; m_sel_i = 4'hF;
    @(posedge clk_i); #1;
    m_op_i = 2'b00;
    repeat (5) @(posedge clk_i);
    #1;
    check_eq("mid_resp_op", s_op_o, 2'b00);
    check_eq("mid_resp_addr", s_addr_o, {30'h3, 2'd2});
    check_eq("mid_busy", m_rdy_o, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; s_rdy_i = 1'b0;
    check_eq("midrst_m_rdy", m_rdy_o, 1'b1);
    check_eq("midrst_s_op", s_op_o, 2'b00);
    check_eq("midrst_m_data", m_data_o, 32'd0);
    do_txn(2'b10, 30'h77, 32'h0, 4'b1111, 1'b0, 1'b0, -1, 0);

    // sparse WR, all-zero-sel RD, stalled RW
    do_txn(2'b01, 30'h20, 32'hAABBCCDD, 4'b0100, 1'b0, 1'b0, -1, 0);
    do_txn(2'b10, 30'h44, 32'h0, 4'b0000, 1'b0, 1'b0, -1, 0);
    do_txn(2'b11, 30'h155, 32'h12345678, 4'b1111, 1'b0, 1'b0, 1, 5);

    // randomized traffic with random slave stalls
    for (int t = 0; t < 40; t++) begin
      rop  = 2'($urandom_range(1, 3));
      rsel = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      do_txn(rop, 30'($urandom), $urandom, rsel, 1'b1, 1'b0, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pi1_dcv.md
# pi1_dcv

Peripheral-interconnect data-width down-converter. It sits downstream of the pi1 pipeline buffer and converts one wide master access into a sequence of narrow slave accesses. Each narrow access is one beat; beats are serialised. Read data is reassembled into one wide word. Its job is to let 8- or 16-bit peripherals hang off the 32/64-bit interconnect.

## Interface
- MARCHBITSZ, 32: master data width; power of two, at least 16.
- SARCHBITSZ, 8: slave data width; power of two, at least 8 and less than MARCHBITSZ.
- Derived: R = MARCHBITSZ/SARCHBITSZ (number of beats).
- Derived: MADDRBITSZ = MARCHBITSZ - clog2(MARCHBITSZ/8).
- Derived: SADDRBITSZ = MADDRBITSZ + clog2(R).
- Reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- m_op_i  in  2  master op: 00 NOOP, 01 WR, 10 RD, 11 RW.
- m_addr_i  in  MADDRBITSZ  master word address.
- m_data_i  in  MARCHBITSZ  master write data.
- m_data_o  out  MARCHBITSZ  reassembled read data.
- m_sel_i  in  MARCHBITSZ/8  master byte selects.
- m_rdy_o  out  1  ready / done.
- s_op_o  out  2  slave op.
- s_addr_o  out  SADDRBITSZ  slave word address.
- s_data_o  out  SARCHBITSZ  slave write data.
- s_data_i  in  SARCHBITSZ  slave read data.
- s_sel_o  out  SARCHBITSZ/8  slave byte selects.
- s_rdy_i  in  1  slave ready / done.

## Operation
- Master accept: on a clock edge where m_rdy_o=1 and m_op_i!=NOOP. At that edge, op, addr, data and sel are registered and m_rdy_o drops to 0.
- Beat numbering: beat k carries master lanes [k*SARCHBITSZ +: SARCHBITSZ], little-endian, so beat 0 is the lowest address.
  - s_addr_o = {addr, k}.
  - s_data_o = write lane k.
  - s_sel_o = sel slice k.
- State machine:
  - IDLE: m_rdy_o=1, s_op_o=NOOP. Accept moves to BEAT, loading the first beat.
  - BEAT: s_op_o = latched op. An edge with s_rdy_i=1 means the slave has accepted the beat; go to RESP with s_op_o=NOOP.
  - RESP: an edge with s_rdy_i=1 means the beat is complete.
    - Capture s_data_i into lane k for RD/RW; WR leaves the lane 0.
    - If beats remain, load the next beat and go to BEAT.
    - Otherwise go to IDLE with m_rdy_o=1.
- Read data:
  - m_data_o updates only at the final completion edge.
  - It then holds until the next transaction completes.
  - Lanes not transferred read as 0.
- RW on a slave beat: write s_data_o and return the old value, the same semantics as on the master side.
- While BEAT is waiting, s_op_o, s_addr_o, s_data_o and s_sel_o are held stable.
- Reset at any state:
  - Next state is IDLE, the transaction is dropped, with no slave completion awaited.
  - s_op_o=NOOP, m_rdy_o=1.
  - Datapath registers are cleared to 0.
- Reset values: m_rdy_o=1, m_data_o=0, s_op_o=NOOP, s_addr_o=0, s_data_o=0, s_sel_o=0.
- m_op_i is ignored while m_rdy_o=0.

## Timing
- The slave op is registered: the first beat is on s_op_o in the cycle after master accept.
- Each beat costs at least 2 edges (accept, then completion). The next beat's op is presented at the completion edge of the previous beat, so no bubble is added.
- Zero-wait slave (s_rdy_i held 1) with all N beats active: m_rdy_o stays low for 2N cycles after the accept edge.
- Slave stalls extend BEAT or RESP by one cycle per low s_rdy_i, with no upper bound.

## Configuration
- Macro: PI1_DCV_SKIPZEROSEL_EN.
- Defined:
  - Beats whose sel slice is 0 are never issued; the scan jumps to the next nonzero slice.
  - An access with m_sel_i=0 issues no beats; m_rdy_o returns to 1 one cycle after accept, with m_data_o=0.
- Undefined:
  - All R beats are always issued, including those with s_sel_o=0.
  - Latency is fixed at 2R cycles with a zero-wait slave.

## Structure
- Op localparams (PINOOP, PIWROP, PIRDOP, PIRWOP) and clog2 live in the shared pi1 package/include, used by all pi1 blocks.
- Sub-module pi1_dcv_selscan: combinational next-active-beat finder.
  - Inputs: sel vector and current beat index.
  - Outputs: next index and a "none left" flag.
  - With the macro undefined it reduces to an incrementer.

## Test plan
Settings: MARCHBITSZ=32, SARCHBITSZ=8, zero-wait slave unless stated.
- RD addr 0x100, sel 4'b1111, slave returns 0x11/0x22/0x33/0x44 -> s_addr 0x400..0x403 in order, m_data_o=0x44332211, m_rdy_o low for 8 cycles.
- WR addr 0x20, data 0xAABBCCDD, sel 4'b0100 with macro defined -> exactly one slave op: addr 0x82, data 0xBB, sel 1; m_rdy_o low for 2 cycles.
- Same WR with macro undefined -> 4 beats with s_sel_o 0,0,1,0; m_rdy_o low for 8 cycles.
- RD sel 0 with macro defined -> no slave op, m_rdy_o=1 one cycle after accept, m_data_o=0.
- Slave holds s_rdy_i=0 for 5 cycles during beat 1 -> s_op_o/s_addr_o/s_data_o/s_sel_o stable for all 5 cycles, with no beat skipped or duplicated.
- rst_i asserted during RESP of beat 2 -> next cycle m_rdy_o=1, s_op_o=NOOP, m_data_o=0; a following RD completes normally.
